leddisplay: RTL
===============

LEDDISPLAY -- requirements
Module: leddisplay

Interface
REQ-001 SHALL have parameter NDIGITS, default 6, giving the number of 7-segment digits driven (1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, giving clock cycles per blink phase (>=2).
REQ-003 SHALL have port clk  input  1  system clock, all state on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load  input  1  strobe that captures value, dots and blink_mask.
REQ-006 SHALL have port value  input  4*NDIGITS  hex nibbles, digit 0 in bits [3:0] (least significant).
REQ-007 SHALL have port dots  input  NDIGITS  decimal point request per digit, 1 = lit.
REQ-008 SHALL have port blink_mask  input  NDIGITS  per-digit blink enable, 1 = blink.
REQ-009 SHALL have port lzb_en  input  1  leading-zero blanking enable, sampled every cycle.
REQ-010 SHALL have port led  output  8*NDIGITS  active-low segments, per digit bit 7 = dot, bits 6:0 = g..a.
REQ-011 SHALL have port blink_phase  output  1  current blink phase, 1 = visible.

Function
REQ-012 SHALL register value, dots and blink_mask into holding registers on the cycle load is 1; load 0 holds them.
REQ-013 SHALL drive led from registered state only; latency from load sampled to led change is exactly 1 cycle.
REQ-014 SHALL decode nibbles 0..F to the standard active-low hex glyphs (0 = 1000000, 8 = 0000000, F = 0001110).
REQ-015 SHALL drive dot bit 0 for a digit whose registered dots bit is 1, else 1.
REQ-016 SHALL, with lzb_en = 1, blank (8'hFF, dot included) every digit above the most significant nonzero nibble.
REQ-017 SHALL never blank digit 0 by leading-zero blanking; value all zero with lzb_en = 1 shows a single "0".
REQ-018 SHALL apply lzb_en combinationally on registered value, so toggling it changes led in the same cycle.
REQ-019 SHALL keep a prescaler counter of width $clog2(BLINK_DIV) counting 0..BLINK_DIV-1 then wrapping to 0.
REQ-020 SHALL toggle blink_phase on the cycle the prescaler wraps; period = 2*BLINK_DIV cycles.
REQ-021 SHALL drive a digit to 8'hFF while blink_phase = 0 and its registered blink_mask bit is 1.
REQ-022 SHALL NOT reset or disturb prescaler or blink_phase on load; load coinciding with wrap applies both.
REQ-023 SHALL give blanking priority: blink-off or leading-zero blank overrides glyph and dot.

Reset
REQ-024 SHALL on reset_n = 0 clear value, dots, blink_mask registers and prescaler to 0, and set blink_phase to 1.
REQ-025 SHALL therefore show "0" with no dot on every digit (led digit = 8'hC0) while and after reset until load.
REQ-026 SHALL abort any blink phase in progress on reset mid-operation; first toggle occurs BLINK_DIV cycles after release.

Configuration
REQ-027 SHALL compile the blink feature only when macro LEDDISPLAY_BLINK_EN is defined.
REQ-028 SHALL, with LEDDISPLAY_BLINK_EN defined, behave per REQ-019..REQ-023.
REQ-029 SHALL, without LEDDISPLAY_BLINK_EN, omit prescaler and blink_mask register, ignore blink_mask, tie blink_phase to 1.

Structure
REQ-030 SHALL place the 16-entry segment glyph table, the 8'hFF blank constant and a seg_t (8-bit) typedef in shared package leddisplay_pkg.
REQ-031 SHALL instantiate NDIGITS copies of sub-module segdecode (nibble + dot + blank -> 8-bit active-low segments), purely combinational.

Verification
REQ-032 SHALL cover: NDIGITS=6, reset release -> all digits 8'hC0, blink_phase 1.
REQ-033 SHALL cover: load value=24'h00A05F, dots=6'b000010 -> next cycle digits 0..5 = F,5,0,A,0,0 glyphs; digit 1 bit 7 = 0.
REQ-034 SHALL cover: same value, lzb_en=1 -> digits 4,5 = 8'hFF, digit 3 = A glyph, digit 2 = 0 glyph (inner zero kept).
REQ-035 SHALL cover: value=0, lzb_en=1 -> digit 0 = 8'hC0, digits 1..5 = 8'hFF.
REQ-036 SHALL cover: BLINK_DIV=4, blink_mask=6'b000001 -> blink_phase toggles every 4 cycles; digit 0 = 8'hFF when phase 0, others unchanged.
REQ-037 SHALL cover: reset_n asserted mid-blink-off phase -> immediate 8'hC0 and blink_phase 1; compile without LEDDISPLAY_BLINK_EN -> no blanking ever.

Source files
------------

// File: rtl/leddisplay_pkg.sv
// Shared types and constants for the leddisplay 7-segment driver:
// active-low segment word, hex glyph table and blink phase encoding.
package leddisplay_pkg;

  typedef logic [7:0] seg_t;

  typedef enum logic {
    BLINK_OFF = 1'b0,
    BLINK_ON  = 1'b1
  } blink_phase_e;

  localparam seg_t SEG_BLANK = 8'hFF;

  // Index n holds the glyph for nibble n; bit 7 (dot) is off, bits 6:0 = g..a.
  localparam seg_t [15:0] SEG_GLYPH = {
    8'h8E, // F
    8'h86, // E
    8'hA1, // d
    8'hC6, // C
    8'h83, // b
    8'h88, // A
    8'h90, // 9
    8'h80, // 8
    8'hF8, // 7
    8'h82, // 6
    8'h92, // 5
    8'h99, // 4
    8'hB0, // 3
    8'hA4, // 2
    8'hF9, // 1
    8'hC0  // 0
  };

endpackage

// File: rtl/leddisplay_segdecode.sv
// Combinational per-digit decoder: nibble + dot + blank -> active-low segments.
module segdecode
  import leddisplay_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dot,
  input  logic       blank,
  output seg_t       seg
);

  seg_t glyph;

  always_comb begin
    glyph = SEG_GLYPH[nibble];
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = {~dot, glyph[6:0]};
    end
  end

endmodule

// File: rtl/leddisplay.sv
// Multi-digit hex 7-segment driver with leading-zero blanking and optional
// per-digit blinking (compiled in only when LEDDISPLAY_BLINK_EN is defined).
module leddisplay
  import leddisplay_pkg::*;
#(
  parameter int unsigned NDIGITS   = 6,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dots,
  input  logic [NDIGITS-1:0]     blink_mask,
  input  logic                   lzb_en,
  output logic [8*NDIGITS-1:0]   led,
  output logic                   blink_phase
);

  logic [4*NDIGITS-1:0] value_q, value_d;
  logic [NDIGITS-1:0]   dots_q, dots_d;
  logic [NDIGITS-1:0]   lzb_blank;
  logic [NDIGITS-1:0]   blink_off;
  logic [NDIGITS-1:0]   blank;
  logic                 seen_nz;

  always_comb begin
    value_d = load ? value : value_q;
    dots_d  = load ? dots  : dots_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      dots_q  <= '0;
    end else begin
      value_q <= value_d;
      dots_q  <= dots_d;
    end
  end

  // Scan from the top digit down; a digit is blanked until the first nonzero
  // nibble is seen, and digit 0 is always shown.
  always_comb begin
    seen_nz   = 1'b0;
    lzb_blank = '0;
    for (int unsigned k = 0; k < NDIGITS; k++) begin
      if (value_q[4*(NDIGITS-1-k) +: 4] != 4'h0) begin
        seen_nz = 1'b1;
      end
      lzb_blank[NDIGITS-1-k] = lzb_en && !seen_nz && (k != NDIGITS-1);
    end
  end

`ifdef LEDDISPLAY_BLINK_EN
  localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0]      presc_q, presc_d;
  logic [NDIGITS-1:0] mask_q, mask_d;
  blink_phase_e       phase_q, phase_d;

  always_comb begin
    mask_d = load ? blink_mask : mask_q;
    if (presc_q == CW'(BLINK_DIV - 1)) begin
      presc_d = '0;
      phase_d = (phase_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
    end else begin
      presc_d = presc_q + 1'b1;
      phase_d = phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      phase_q <= BLINK_ON;
      mask_q  <= '0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  assign blink_phase = (phase_q == BLINK_ON);
  assign blink_off   = (phase_q == BLINK_OFF) ? mask_q : '0;
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask ^ BLINK_DIV[0];
  assign blink_phase  = 1'b1;
  assign blink_off    = '0;
`endif

  assign blank = lzb_blank | blink_off;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    segdecode u_segdecode (
      .nibble (value_q[4*i +: 4]),
      .dot    (dots_q[i]),
      .blank  (blank[i]),
      .seg    (led[8*i +: 8])
    );
  end

endmodule
